// File: rtl/mem_wb_pkg.sv
// Shared definitions for the elastic MEM/WB stage: occupancy states and
// bit positions inside the write-back control word and instruction.
package mem_wb_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_e;

  localparam int unsigned WB_REGWRITE_BIT = 0;
  localparam int unsigned WB_MEMTOREG_BIT = 1;
  localparam int unsigned RD_LSB          = 7;
  localparam int unsigned RD_MSB          = 11;
  localparam int unsigned RD_W            = RD_MSB - RD_LSB + 1;

endpackage

// File: rtl/mem_wb_elastic_sat_counter.sv
// Saturating up-counter; sticks at all-ones until reset.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_wb_elastic.sv
// Elastic MEM/WB stage: main (head) register plus one skid register,
// valid/ready handshake, synchronous flush and a saturating stall counter.
module mem_wb_elastic
  import mem_wb_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned WB_W    = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inValid,
  output logic               inReady,
  input  logic               flush,
  input  logic [WB_W-1:0]    WB,
  input  logic [WIDTH-1:0]   readData,
  input  logic [WIDTH-1:0]   aluResult,
  input  logic [INSTR_W-1:0] instruction,
  output logic               outValid,
  input  logic               outReady,
  output logic               regWriteOut,
  output logic               memToRegOut,
  output logic [WB_W-1:0]    wbCtrlOut,
  output logic [WIDTH-1:0]   readDataOut,
  output logic [WIDTH-1:0]   aluResultOut,
  output logic [INSTR_W-1:0] instructionOut,
  output logic [WIDTH-1:0]   wbDataOut,
  output logic [RD_W-1:0]    rdOut,
  output logic [CNT_W-1:0]   stallCount
);

  localparam int unsigned PAY_W = WB_W + 2 * WIDTH + INSTR_W;

  state_e             state;
  state_e             state_nxt;
  logic [PAY_W-1:0]   in_payload;
  logic [PAY_W-1:0]   main_q;
  logic [PAY_W-1:0]   skid_q;
  logic               accept;
  logic               consume;
  logic               load_main;
  logic               main_from_skid;
  logic               load_skid;

  assign in_payload = {WB, readData, aluResult, instruction};

  // Ready depends on state only, so back-pressure never ripples upstream combinationally.
  assign inReady  = (state != SKID);
  assign outValid = (state != EMPTY);
  assign accept   = inValid & inReady & ~flush;
  assign consume  = outValid & outReady;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = FULL;
            load_main = 1'b1;
          end
        end
        FULL: begin
          if (accept && consume) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_nxt = SKID;
            load_skid = 1'b1;
          end else if (consume) begin
            state_nxt = EMPTY;
          end
        end
        SKID: begin
          if (consume) begin
            state_nxt      = FULL;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= '0;
    end else if (load_main) begin
      main_q <= main_from_skid ? skid_q : in_payload;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_q <= '0;
    end else if (load_skid) begin
      skid_q <= in_payload;
    end
  end

  // Head-entry field extraction; decoded outputs come from the main register only.
  assign wbCtrlOut      = main_q[PAY_W-1 -: WB_W];
  assign readDataOut    = main_q[2*WIDTH+INSTR_W-1 -: WIDTH];
  assign aluResultOut   = main_q[WIDTH+INSTR_W-1 -: WIDTH];
  assign instructionOut = main_q[INSTR_W-1:0];
  assign regWriteOut    = wbCtrlOut[WB_REGWRITE_BIT] & outValid;
  assign memToRegOut    = wbCtrlOut[WB_MEMTOREG_BIT];
  assign wbDataOut      = memToRegOut ? readDataOut : aluResultOut;
  assign rdOut          = instructionOut[RD_MSB:RD_LSB];

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (outValid & ~outReady),
    .count(stallCount)
  );

endmodule

// File: tb/tb_mem_wb_elastic.sv
// Scoreboard bench for mem_wb_elastic: a queue-based occupancy model predicts
// handshake, head entry and stall count; a negedge monitor compares.
module tb_mem_wb_elastic;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid, flush, outReady;
  logic [1:0]  WB;
  logic [31:0] readData, aluResult, instruction;

  logic        inReady, outValid, regWriteOut, memToRegOut;
  logic [1:0]  wbCtrlOut;
  logic [31:0] readDataOut, aluResultOut, instructionOut, wbDataOut;
  logic [4:0]  rdOut;
  logic [15:0] stallCount;

  logic        s_inReady, s_outValid, s_regWriteOut, s_memToRegOut;
  logic [1:0]  s_wbCtrlOut;
  logic [31:0] s_readDataOut, s_aluResultOut, s_instructionOut, s_wbDataOut;
  logic [4:0]  s_rdOut;
  logic [2:0]  s_stallCount;

  typedef struct {
    logic [1:0]  wb;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [31:0] ins;
  } entry_t;

  entry_t q[$];
  int     stall_m = 0;
  int     tests   = 0;
  int     fails   = 0;

  always #5 clk = ~clk;

  mem_wb_elastic #(.WIDTH(32), .INSTR_W(32), .WB_W(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady), .flush(flush),
    .WB(WB), .readData(readData), .aluResult(aluResult), .instruction(instruction),
    .outValid(outValid), .outReady(outReady), .regWriteOut(regWriteOut),
    .memToRegOut(memToRegOut), .wbCtrlOut(wbCtrlOut), .readDataOut(readDataOut),
    .aluResultOut(aluResultOut), .instructionOut(instructionOut),
    .wbDataOut(wbDataOut), .rdOut(rdOut), .stallCount(stallCount)
  );

  mem_wb_elastic #(.WIDTH(32), .INSTR_W(32), .WB_W(2), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(s_inReady), .flush(flush),
    .WB(WB), .readData(readData), .aluResult(aluResult), .instruction(instruction),
    .outValid(s_outValid), .outReady(outReady), .regWriteOut(s_regWriteOut),
    .memToRegOut(s_memToRegOut), .wbCtrlOut(s_wbCtrlOut), .readDataOut(s_readDataOut),
    .aluResultOut(s_aluResultOut), .instructionOut(s_instructionOut),
    .wbDataOut(s_wbDataOut), .rdOut(s_rdOut), .stallCount(s_stallCount)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two entries, updated at each rising edge.
  always @(posedge clk) begin : model
    int     n;
    entry_t e;
    if (reset) begin
      q.delete();
      stall_m = 0;
    end else begin
      n = q.size();
      if (n > 0 && !outReady) stall_m++;
      if (flush) begin
        q.delete();
      end else begin
        if (n > 0 && outReady) q.delete(0);
        if (inValid && n < 2) begin
          e.wb = WB; e.rd = readData; e.alu = aluResult; e.ins = instruction;
          q.push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    entry_t e;
    int     sat16, sat3;
    sat16 = (stall_m > 65535) ? 65535 : stall_m;
    sat3  = (stall_m > 7) ? 7 : stall_m;
    check("outValid", 64'(outValid), 64'(q.size() > 0));
    check("inReady", 64'(inReady), 64'(q.size() < 2));
    check("stallCount", 64'(stallCount), 64'(sat16));
    check("stallCount_sat3", 64'(s_stallCount), 64'(sat3));
    if (q.size() > 0) begin
      e = q[0];
      check("regWriteOut", 64'(regWriteOut), 64'(e.wb[0]));
      check("memToRegOut", 64'(memToRegOut), 64'(e.wb[1]));
      check("wbCtrlOut", 64'(wbCtrlOut), 64'(e.wb));
      check("readDataOut", 64'(readDataOut), 64'(e.rd));
      check("aluResultOut", 64'(aluResultOut), 64'(e.alu));
      check("instructionOut", 64'(instructionOut), 64'(e.ins));
      check("wbDataOut", 64'(wbDataOut), 64'(e.wb[1] ? e.rd : e.alu));
      check("rdOut", 64'(rdOut), 64'(e.ins[11:7]));
    end else begin
      check("regWriteOut_idle", 64'(regWriteOut), 64'(0));
    end
  end

  task automatic step(input logic iv, input logic ordy, input logic fl, input logic [1:0] wb,
                      input logic [31:0] rd, input logic [31:0] alu, input logic [31:0] ins);
    inValid = iv; outReady = ordy; flush = fl;
    WB = wb; readData = rd; aluResult = alu; instruction = ins;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    inValid = 1'b0; outReady = 1'b0; flush = 1'b0;
    WB = '0; readData = '0; aluResult = '0; instruction = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outValid", 64'(outValid), 64'(0));
    check("rst_inReady", 64'(inReady), 64'(1));
    check("rst_readDataOut", 64'(readDataOut), 64'(0));
    check("rst_aluResultOut", 64'(aluResultOut), 64'(0));
    check("rst_instructionOut", 64'(instructionOut), 64'(0));
    check("rst_wbCtrlOut", 64'(wbCtrlOut), 64'(0));
    check("rst_wbDataOut", 64'(wbDataOut), 64'(0));
    check("rst_rdOut", 64'(rdOut), 64'(0));
    reset = 1'b0;

    // Idle
    repeat (5) step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);

    // Streaming at full rate
    repeat (4) step(1'b1, 1'b1, 1'b0, 2'b01, 32'h1, 32'h2, 32'h00A00093);
    check("stream_rdOut", 64'(rdOut), 64'(1));
    check("stream_wbDataOut", 64'(wbDataOut), 64'(32'h2));
    step(1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);

    // Back-pressure: A, B, C with outReady low, then drain
    step(1'b1, 1'b0, 1'b0, 2'b01, 32'hA, 32'hA0, 32'h00000A80);
    step(1'b1, 1'b0, 1'b0, 2'b01, 32'hB, 32'hB0, 32'h00000B00);
    check("bp_inReady_low", 64'(inReady), 64'(0));
    step(1'b1, 1'b0, 1'b0, 2'b01, 32'hC, 32'hC0, 32'h00000C00);
    repeat (3) step(1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    check("bp_inReady_back", 64'(inReady), 64'(1));

    // Flush while in SKID with an entry on offer
    step(1'b1, 1'b0, 1'b0, 2'b01, 32'h11, 32'h110, 32'h00000880);
    step(1'b1, 1'b0, 1'b0, 2'b01, 32'h22, 32'h220, 32'h00000900);
    step(1'b1, 1'b0, 1'b1, 2'b01, 32'h33, 32'h330, 32'h00000980);
    check("flush_outValid", 64'(outValid), 64'(0));
    check("flush_regWriteOut", 64'(regWriteOut), 64'(0));
    check("flush_inReady", 64'(inReady), 64'(1));
    repeat (2) step(1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);

    // memToReg select
    step(1'b1, 1'b0, 1'b0, 2'b11, 32'hDEAD_BEEF, 32'h10, 32'h00000100);
    check("m2r_wbDataOut", 64'(wbDataOut), 64'(32'hDEAD_BEEF));
    check("m2r_memToRegOut", 64'(memToRegOut), 64'(1));
    step(1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);

    // Async reset between edges while in SKID
    step(1'b1, 1'b0, 1'b0, 2'b01, 32'h44, 32'h440, 32'h00000200);
    step(1'b1, 1'b0, 1'b0, 2'b01, 32'h55, 32'h550, 32'h00000280);
    inValid = 1'b0;
    #2;
    reset = 1'b1;
    q.delete();
    stall_m = 0;
    #1;
    check("arst_outValid", 64'(outValid), 64'(0));
    check("arst_stallCount", 64'(stallCount), 64'(0));
    check("arst_inReady", 64'(inReady), 64'(1));
    check("arst_readDataOut", 64'(readDataOut), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Saturation on the 3-bit counter: 10 stalled cycles
    step(1'b1, 1'b0, 1'b0, 2'b01, 32'h66, 32'h660, 32'h00000300);
    repeat (10) step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    check("sat3_count", 64'(s_stallCount), 64'(7));
    check("sat16_count", 64'(stallCount), 64'(10));

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6),
           1'($urandom_range(0, 15) == 0), 2'($urandom), $urandom, $urandom, $urandom);
    end
    repeat (4) step(1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
